// File: rtl/atm_card_auth_if.sv
// Card/keypad/session signals of the ATM card authentication block.
// master drives card, keypad and session inputs; slave is the authenticator.
interface atm_card_auth_if #(
  parameter int unsigned PIN_DIGITS = 4
);
  logic                    card_valid;
  logic [7:0]              card_no;
  logic [4*PIN_DIGITS-1:0] ref_pin;
  logic                    key_valid;
  logic [3:0]              key_code;
  logic                    session_done;
  logic                    auth_valid;
  logic [7:0]              auth_card;
  logic                    pin_err;
  logic                    retain;
  logic                    eject;
  logic                    timeout;
  logic [2:0]              digit_cnt;

  modport master (
    output card_valid, card_no, ref_pin, key_valid, key_code, session_done,
    input  auth_valid, auth_card, pin_err, retain, eject, timeout, digit_cnt
  );

  modport slave (
    input  card_valid, card_no, ref_pin, key_valid, key_code, session_done,
    output auth_valid, auth_card, pin_err, retain, eject, timeout, digit_cnt
  );
endinterface

// File: rtl/atm_card_auth.sv
// ATM card PIN authentication: collects BCD PIN digits, compares against the
// stored PIN, counts wrong attempts and decides between auth, eject and retain.
module atm_card_auth #(
  parameter int unsigned PIN_DIGITS  = 4,
  parameter int unsigned MAX_TRIES   = 3,
  parameter int unsigned TIMEOUT_CYC = 1000
) (
  input logic            clk,
  input logic            rst,
  atm_card_auth_if.slave bus
);
  localparam int unsigned PW = 4 * PIN_DIGITS;
  localparam int unsigned TW = (MAX_TRIES > 1) ? $clog2(MAX_TRIES + 1) : 1;
  localparam int unsigned IW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_CHECK,
    S_AUTH,
    S_RETAIN,
    S_EJECT
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   pin_buf_q, pin_buf_d;
  logic [PW-1:0]   ref_q, ref_d;
  logic [7:0]      card_q, card_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [TW-1:0]   tries_q, tries_d;
  logic [IW-1:0]   idle_q, idle_d;
  logic            tmo_q, tmo_d;
  logic            pin_err_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pin_buf_q <= '0;
      ref_q     <= '0;
      card_q    <= '0;
      cnt_q     <= '0;
      tries_q   <= '0;
      idle_q    <= '0;
      tmo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pin_buf_q <= pin_buf_d;
      ref_q     <= ref_d;
      card_q    <= card_d;
      cnt_q     <= cnt_d;
      tries_q   <= tries_d;
      idle_q    <= idle_d;
      tmo_q     <= tmo_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pin_buf_d = pin_buf_q;
    ref_d     = ref_q;
    card_d    = card_q;
    cnt_d     = cnt_q;
    tries_d   = tries_q;
    idle_d    = idle_q;
    tmo_d     = 1'b0;
    pin_err_c = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.card_valid && (bus.card_no != 8'h00)) begin
          card_d    = bus.card_no;
          ref_d     = bus.ref_pin;
          pin_buf_d = '0;
          cnt_d     = '0;
          tries_d   = '0;
          idle_d    = '0;
          state_d   = S_COLLECT;
        end
      end

      S_COLLECT: begin
        idle_d = idle_q + IW'(1);
        // Any key, even an unused code, restarts the idle window and beats expiry.
        if (bus.key_valid) begin
          idle_d = '0;
          if (bus.key_code <= 4'd9) begin
            if (cnt_q < 3'(PIN_DIGITS)) begin
              pin_buf_d = (pin_buf_q << 4) | PW'(bus.key_code);
              cnt_d     = cnt_q + 3'd1;
            end
          end else begin
            case (bus.key_code)
              4'hA: begin
                state_d = S_EJECT;
                card_d  = '0;
              end
              4'hB: begin
                if (cnt_q == 3'(PIN_DIGITS)) state_d = S_CHECK;
              end
              4'hC: begin
                pin_buf_d = '0;
                cnt_d     = '0;
              end
              default: ;
            endcase
          end
        end else if (idle_q == IW'(TIMEOUT_CYC - 1)) begin
          state_d = S_EJECT;
          card_d  = '0;
          tmo_d   = 1'b1;
        end
      end

      S_CHECK: begin
        if (pin_buf_q == ref_q) begin
          state_d = S_AUTH;
        end else begin
          pin_err_c = 1'b1;
          tries_d   = tries_q + TW'(1);
          pin_buf_d = '0;
          cnt_d     = '0;
          idle_d    = '0;
          if (tries_q + TW'(1) == TW'(MAX_TRIES)) begin
            state_d = S_RETAIN;
            card_d  = '0;
          end else begin
            state_d = S_COLLECT;
          end
        end
      end

      S_AUTH: begin
        if (bus.session_done) begin
          state_d = S_EJECT;
          card_d  = '0;
        end
      end

      S_RETAIN: state_d = S_IDLE;
      S_EJECT:  state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  assign bus.auth_valid = (state_q == S_AUTH);
  assign bus.auth_card  = card_q;
  assign bus.pin_err    = pin_err_c;
  assign bus.retain     = (state_q == S_RETAIN);
  assign bus.eject      = (state_q == S_EJECT);
  assign bus.timeout    = tmo_q;
  assign bus.digit_cnt  = cnt_q;
endmodule

// File: tb/tb_atm_card_auth.sv
// Directed bench for atm_card_auth: output pulses are matched in order against
// a queue of expected events; levels are checked directly at each step.
module tb_atm_card_auth;
  localparam int unsigned PD = 4;

  localparam logic [2:0] EV_AUTH = 3'd1;
  localparam logic [2:0] EV_PERR = 3'd2;
  localparam logic [2:0] EV_RET  = 3'd3;
  localparam logic [2:0] EV_EJ   = 3'd4;
  localparam logic [2:0] EV_EJT  = 3'd5;
  localparam logic [2:0] EV_TMO  = 3'd6;

  typedef logic [10:0] ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   compared   = 0;
  int   mismatched = 0;
  ev_t  expq[$];
  logic auth_prev = 1'b0;

  atm_card_auth_if #(.PIN_DIGITS(PD)) bus ();

  atm_card_auth #(
    .PIN_DIGITS (PD),
    .MAX_TRIES  (3),
    .TIMEOUT_CYC(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic ev(input logic [2:0] k);
    ev_t e;
    compared++;
    assert (expq.size() > 0) else begin
      mismatched++;
      $error("FAIL ev_unexpected: observed kind %0d card %0h, expected no event", k, bus.auth_card);
    end
    if (expq.size() > 0) begin
      e = expq.pop_front();
      compared++;
      assert ({k, bus.auth_card} === e) else begin
        mismatched++;
        $error("FAIL ev_order: observed kind %0d card %0h, expected kind %0d card %0h",
               k, bus.auth_card, e[10:8], e[7:0]);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.auth_valid && !auth_prev) ev(EV_AUTH);
      if (bus.pin_err) ev(EV_PERR);
      if (bus.retain) ev(EV_RET);
      if (bus.eject) ev(bus.timeout ? EV_EJT : EV_EJ);
      else if (bus.timeout) ev(EV_TMO);
    end
    auth_prev = bus.auth_valid;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_ev(input logic [2:0] k, input logic [7:0] c);
    expq.push_back({k, c});
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic insert(input logic [7:0] c, input logic [15:0] p);
    bus.card_valid = 1'b1;
    bus.card_no    = c;
    bus.ref_pin    = p;
    step(1);
    bus.card_valid = 1'b0;
  endtask

  task automatic press(input logic [3:0] k);
    bus.key_valid = 1'b1;
    bus.key_code  = k;
    step(1);
    bus.key_valid = 1'b0;
  endtask

  task automatic pin4(input logic [15:0] p);
    for (int i = 3; i >= 0; i--) press(p[4*i +: 4]);
  endtask

  task automatic end_session();
    expect_ev(EV_EJ, 8'h00);
    bus.session_done = 1'b1;
    step(1);
    bus.session_done = 1'b0;
    chk("sess_eject", bus.eject, 1);
    chk("sess_card_clr", bus.auth_card, 8'h00);
    chk("sess_auth_drop", bus.auth_valid, 0);
    step(1);
    chk("sess_eject_once", bus.eject, 0);
  endtask

  task automatic wrong_try(input logic [7:0] c);
    pin4(16'h9999);
    expect_ev(EV_PERR, c);
    press(4'hB);
    chk("perr_pulse", bus.pin_err, 1);
    step(1);
    chk("perr_once", bus.pin_err, 0);
  endtask

  initial begin
    bus.card_valid   = 1'b0;
    bus.card_no      = 8'h00;
    bus.ref_pin      = '0;
    bus.key_valid    = 1'b0;
    bus.key_code     = 4'h0;
    bus.session_done = 1'b0;

    step(2);
    chk("rst_auth_valid", bus.auth_valid, 0);
    chk("rst_auth_card", bus.auth_card, 8'h00);
    chk("rst_digit_cnt", bus.digit_cnt, 0);
    chk("rst_pin_err", bus.pin_err, 0);
    chk("rst_retain", bus.retain, 0);
    chk("rst_eject", bus.eject, 0);
    chk("rst_timeout", bus.timeout, 0);
    rst = 1'b0;
    step(1);

    // Good PIN, two-cycle auth latency, card_valid ignored in AUTH, session end
    insert(8'h5A, 16'h1234);
    chk("collect_cnt0", bus.digit_cnt, 0);
    pin4(16'h1234);
    chk("cnt_full", bus.digit_cnt, 4);
    expect_ev(EV_AUTH, 8'h5A);
    press(4'hB);
    chk("auth_lat_1", bus.auth_valid, 0);
    step(1);
    chk("auth_lat_2", bus.auth_valid, 1);
    chk("auth_card", bus.auth_card, 8'h5A);
    bus.card_valid = 1'b1;
    bus.card_no    = 8'h33;
    bus.ref_pin    = 16'h9999;
    step(1);
    bus.card_valid = 1'b0;
    chk("auth_card_hold", bus.auth_card, 8'h5A);
    chk("auth_hold", bus.auth_valid, 1);
    end_session();

    // Three wrong PINs lead to retain without eject
    insert(8'h5A, 16'h1234);
    for (int t = 1; t <= 3; t++) begin
      if (t == 3) begin
        pin4(16'h9999);
        expect_ev(EV_PERR, 8'h5A);
        expect_ev(EV_RET, 8'h00);
        press(4'hB);
        chk("perr_last", bus.pin_err, 1);
        step(1);
      end else begin
        wrong_try(8'h5A);
      end
      chk("retain_level", bus.retain, (t == 3) ? 1 : 0);
    end
    chk("retain_no_eject", bus.eject, 0);
    chk("retain_card_clr", bus.auth_card, 8'h00);
    step(1);
    chk("retain_once", bus.retain, 0);
    press(4'h1);
    chk("idle_keys_ignored", bus.digit_cnt, 0);

    // Short enter ignored, clear, digit saturation
    insert(8'h5A, 16'h1234);
    press(4'h1);
    press(4'h2);
    press(4'hB);
    chk("short_enter_cnt", bus.digit_cnt, 2);
    step(1);
    chk("short_enter_noauth", bus.auth_valid, 0);
    press(4'hC);
    chk("clear_cnt", bus.digit_cnt, 0);
    pin4(16'h1234);
    press(4'h5);
    chk("cnt_saturate", bus.digit_cnt, 4);
    expect_ev(EV_AUTH, 8'h5A);
    press(4'hB);
    step(1);
    chk("sat_auth", bus.auth_valid, 1);
    end_session();

    // Keypad inactivity: expiry at 8 cycles, then a key on the expiry cycle
    insert(8'h77, 16'h1234);
    expect_ev(EV_EJT, 8'h00);
    step(7);
    chk("tmo_early_eject", bus.eject, 0);
    chk("tmo_early_timeout", bus.timeout, 0);
    step(1);
    chk("tmo_eject", bus.eject, 1);
    chk("tmo_timeout", bus.timeout, 1);
    chk("tmo_card_clr", bus.auth_card, 8'h00);
    step(1);
    chk("tmo_once", bus.timeout, 0);
    insert(8'h77, 16'h1234);
    step(7);
    press(4'h1);
    chk("tmo_key_wins_t", bus.timeout, 0);
    chk("tmo_key_wins_e", bus.eject, 0);
    chk("tmo_key_digit", bus.digit_cnt, 1);
    expect_ev(EV_EJ, 8'h00);
    press(4'hA);
    chk("cancel_eject", bus.eject, 1);
    chk("cancel_no_tmo", bus.timeout, 0);
    step(1);

    // Reset mid-session clears tries
    insert(8'h5A, 16'h1234);
    wrong_try(8'h5A);
    wrong_try(8'h5A);
    press(4'h9);
    rst = 1'b1;
    #2;
    chk("arst_digit_cnt", bus.digit_cnt, 0);
    chk("arst_card", bus.auth_card, 8'h00);
    step(2);
    rst = 1'b0;
    step(1);
    insert(8'h5A, 16'h1234);
    wrong_try(8'h5A);
    chk("post_rst_no_retain1", bus.retain, 0);
    wrong_try(8'h5A);
    chk("post_rst_no_retain2", bus.retain, 0);
    expect_ev(EV_EJ, 8'h00);
    press(4'hA);
    chk("post_rst_cancel", bus.eject, 1);
    step(1);

    // Card number 0 is not a card
    insert(8'h00, 16'h1234);
    press(4'h1);
    chk("zero_card_cnt", bus.digit_cnt, 0);
    chk("zero_card_held", bus.auth_card, 8'h00);

    step(3);
    compared++;
    assert (expq.size() == 0) else begin
      mismatched++;
      $error("FAIL ev_missing: observed %0d pending events, expected 0", expq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/atm_card_auth.md
ATM_CARD_AUTH -- requirements
Module: atm_card_auth

Interface
REQ-001 Parameter PIN_DIGITS, default 4, SHALL set the number of decimal PIN digits per entry.
REQ-002 Parameter MAX_TRIES, default 3, SHALL set the number of wrong PIN attempts allowed before the card is retained.
REQ-003 Parameter TIMEOUT_CYC, default 1000, SHALL set the number of keypad-idle cycles allowed before the card is ejected.
REQ-004 clk  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-005 rst  in  1  SHALL be an asynchronous, active-high reset.
REQ-006 card_valid  in  1  SHALL be a one-cycle strobe marking a card insertion.
REQ-007 card_no  in  8  SHALL carry the card number; sampled when card_valid=1.
REQ-008 ref_pin  in  4*PIN_DIGITS  SHALL carry the stored BCD PIN for the card; sampled with card_no.
REQ-009 key_valid  in  1  SHALL be a one-cycle keypad strobe.
REQ-010 key_code  in  4  SHALL encode the key: 0-9 digit, 4'hA cancel, 4'hB enter, 4'hC clear; other codes ignored.
REQ-011 session_done  in  1  SHALL be driven by the downstream transaction FSM when the customer session ends.
REQ-012 auth_valid  out  1  SHALL be high while the card is authenticated (AUTH state).
REQ-013 auth_card  out  8  SHALL hold the captured card number; 8'h00 when no card is held.
REQ-014 pin_err  out  1  SHALL pulse for one cycle per wrong PIN attempt.
REQ-015 retain  out  1  SHALL pulse for one cycle when the card is locked and kept.
REQ-016 eject  out  1  SHALL pulse for one cycle when the card is returned.
REQ-017 timeout  out  1  SHALL pulse for one cycle, coincident with the move to EJECT, on keypad inactivity.
REQ-018 digit_cnt  out  3  SHALL report digits entered so far, saturating at PIN_DIGITS.

Function
REQ-019 States SHALL be IDLE, COLLECT, CHECK, AUTH, RETAIN, EJECT.
REQ-020 IDLE: card_valid=1 SHALL capture card_no and ref_pin, clear the digit buffer, tries and idle counter, and enter COLLECT next cycle; card_no=8'h00 SHALL be ignored.
REQ-021 card_valid in any state other than IDLE SHALL be ignored.
REQ-022 COLLECT: a digit key with digit_cnt<PIN_DIGITS SHALL shift into the buffer LSB-nibble and increment digit_cnt; further digits SHALL be ignored.
REQ-023 COLLECT: clear SHALL zero the buffer and digit_cnt without consuming an attempt.
REQ-024 COLLECT: enter with digit_cnt==PIN_DIGITS SHALL move to CHECK; enter with fewer digits SHALL be ignored.
REQ-025 COLLECT: cancel SHALL move to EJECT.
REQ-026 The idle counter SHALL reset on every key_valid and on COLLECT entry; when it reaches TIMEOUT_CYC-1 without a key the block SHALL move to EJECT and pulse timeout; a key in that same cycle SHALL win and no timeout occurs.
REQ-027 CHECK (exactly one cycle): buffer==ref_pin SHALL move to AUTH; otherwise tries SHALL increment, pin_err SHALL pulse, the buffer and digit_cnt SHALL clear, and the next state SHALL be RETAIN if tries reaches MAX_TRIES, else COLLECT.
REQ-028 Latency from the enter strobe to auth_valid=1 SHALL be 2 cycles.
REQ-029 AUTH: keys SHALL be ignored; session_done=1 SHALL move to EJECT; no timeout applies.
REQ-030 RETAIN SHALL pulse retain for one cycle, clear auth_card to 8'h00, and return to IDLE; no eject pulse.
REQ-031 EJECT SHALL pulse eject for one cycle, clear auth_card to 8'h00, and return to IDLE.
REQ-032 The buffer SHALL never be exposed on any output.

Reset
REQ-033 rst=1 SHALL immediately force IDLE and drive auth_valid, pin_err, retain, eject, timeout=0, auth_card=8'h00, and digit_cnt=0.
REQ-034 rst=1 SHALL clear the buffer, tries and idle counter; reset mid-session SHALL produce neither eject nor retain.

Verification
REQ-035 card 8'h5A with ref_pin 16'h1234; keys 1,2,3,4,enter -> auth_valid=1 two cycles after enter, auth_card=8'h5A; session_done -> single eject pulse, auth_card=8'h00.
REQ-036 ref_pin 16'h1234; enter 9999 three times -> three pin_err pulses, then one retain pulse, no eject, state IDLE.
REQ-037 Keys 1,2,enter -> ignored, digit_cnt=2; then clear, 1,2,3,4,5,enter -> digit_cnt saturates at 4, auth succeeds.
REQ-038 TIMEOUT_CYC=8; card inserted, no keys -> timeout and eject pulse together 8 cycles after COLLECT entry; key on the expiry cycle -> no timeout.
REQ-039 Assert rst during COLLECT after 2 wrong tries, then reinsert the card and make a wrong try -> tries restarts at 1, no retain.
REQ-040 Keys cancel in COLLECT -> eject pulse next cycle; card_valid during AUTH -> ignored, auth_card unchanged.
